// File: rtl/dport_sram_resp.sv
// Data-port responder: word SRAM behind an address window, in-order tagged acks after a
// fixed LATENCY, with the number of accepted-but-unacked requests capped via accept.
module dport_sram_resp #(
   parameter int          MEM_AW          = 14,
   parameter logic [31:0] BASE_ADDR       = 32'h80000000,
   parameter int          LATENCY         = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] mem_d_addr_i,
   input  logic [31:0] mem_d_data_wr_i,
   input  logic        mem_d_rd_i,
   input  logic [3:0]  mem_d_wr_i,
   input  logic        mem_d_cacheable_i,
   input  logic [10:0] mem_d_req_tag_i,
   input  logic        mem_d_invalidate_i,
   input  logic        mem_d_writeback_i,
   input  logic        mem_d_flush_i,
   output logic [31:0] mem_d_data_rd_o,
   output logic        mem_d_accept_o,
   output logic        mem_d_ack_o,
   output logic        mem_d_error_o,
   output logic [10:0] mem_d_resp_tag_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic        vld;
      logic [10:0] tag;
      logic        err;
      logic [31:0] data;
   } resp_t;

   resp_t         r_pipe [1:LATENCY];
   logic [31:0]   r_mem  [0:(1<<MEM_AW)-1];
   logic [CW-1:0] r_cnt;
   logic          r_rst_seen;

   logic              w_req;
   logic              w_rdwr;
   logic              w_fire;
   logic              w_inwin;
   logic              w_ack;
   logic [MEM_AW-1:0] w_idx;
   logic              w_unused_ok;

   assign w_rdwr      = mem_d_rd_i | (|mem_d_wr_i);
   assign w_req       = w_rdwr | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
   assign w_fire      = w_req & mem_d_accept_o;
   assign w_inwin     = (mem_d_addr_i[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
   assign w_idx       = mem_d_addr_i[MEM_AW+1:2];
   assign w_ack       = r_pipe[LATENCY].vld;
   assign w_unused_ok = ^{mem_d_cacheable_i, mem_d_addr_i[1:0]};

   // accept is purely registered so the initiator never sees a comb loop
   assign mem_d_accept_o   = r_rst_seen & (r_cnt < CW'(MAX_OUTSTANDING));
   assign mem_d_ack_o      = w_ack;
   assign mem_d_resp_tag_o = r_pipe[LATENCY].tag;
   assign mem_d_error_o    = r_pipe[LATENCY].err;
   assign mem_d_data_rd_o  = r_pipe[LATENCY].data;

   // Array is not reset; writes are only possible once accept is up
   always_ff @(posedge clk_i) begin
      if (w_fire && (|mem_d_wr_i) && w_inwin) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_d_wr_i[b]) r_mem[w_idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
         end
      end
   end

   // Idle stages carry all-zero payloads, so outputs read 0 whenever ack is low
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_pipe[1] <= '0;
      end else if (w_fire) begin
         r_pipe[1].vld  <= 1'b1;
         r_pipe[1].tag  <= mem_d_req_tag_i;
         r_pipe[1].err  <= w_rdwr & ~w_inwin;
         r_pipe[1].data <= (mem_d_rd_i && w_inwin) ? r_mem[w_idx] : 32'h0;
      end else begin
         r_pipe[1] <= '0;
      end
   end

   genvar g;
   generate
      for (g = 2; g <= LATENCY; g++) begin : g_stage
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) r_pipe[g] <= '0;
            else        r_pipe[g] <= r_pipe[g-1];
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt      <= '0;
         r_rst_seen <= 1'b0;
      end else begin
         r_rst_seen <= 1'b1;
         if (w_fire && !w_ack)      r_cnt <= r_cnt + 1'b1;
         else if (!w_fire && w_ack) r_cnt <= r_cnt - 1'b1;
      end
   end

   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(w_ack && r_cnt == '0));

endmodule

// File: tb/tb_dport_sram_resp.sv
// Bench for dport_sram_resp: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a queue/array reference model.
module tb_dport_sram_resp;

   localparam int LAT  = 3;
   localparam int MAXO = 2;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
   logic        mem_d_rd_i, mem_d_cacheable_i;
   logic [3:0]  mem_d_wr_i;
   logic [10:0] mem_d_req_tag_i;
   logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
   logic [31:0] mem_d_data_rd_o;
   logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
   logic [10:0] mem_d_resp_tag_o;

   always #5 clk_i = ~clk_i;

   dport_sram_resp #(.MEM_AW(14), .BASE_ADDR(32'h80000000), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
      .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_cacheable_i(mem_d_cacheable_i),
      .mem_d_req_tag_i(mem_d_req_tag_i), .mem_d_invalidate_i(mem_d_invalidate_i),
      .mem_d_writeback_i(mem_d_writeback_i), .mem_d_flush_i(mem_d_flush_i),
      .mem_d_data_rd_o(mem_d_data_rd_o), .mem_d_accept_o(mem_d_accept_o),
      .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
      .mem_d_resp_tag_o(mem_d_resp_tag_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic [10:0] tag;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_mem [int];
   logic        m_seen = 1'b0;
   logic        m_acc  = 1'b0;

   always @(posedge clk_i) begin : model
      exp_t        e;
      int          idx;
      logic        inwin;
      logic [31:0] w;
      cyc = cyc + 1;
      if (!rst_i) begin
         q.delete();
         m_seen = 1'b0;
      end else begin
         if (m_acc && (mem_d_rd_i || (mem_d_wr_i != 4'h0) || mem_d_invalidate_i ||
                       mem_d_writeback_i || mem_d_flush_i)) begin
            inwin  = (mem_d_addr_i >= 32'h80000000) && (mem_d_addr_i < 32'h80010000);
            idx    = int'((mem_d_addr_i - 32'h80000000) / 4);
            e.due  = cyc + LAT - 1;
            e.tag  = mem_d_req_tag_i;
            e.err  = (mem_d_rd_i || (mem_d_wr_i != 4'h0)) && !inwin;
            e.data = 32'h0;
            if (mem_d_rd_i && inwin) e.data = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
            if ((mem_d_wr_i != 4'h0) && inwin) begin
               w = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
               for (int b = 0; b < 4; b++)
                  if (mem_d_wr_i[b]) w[8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
               m_mem[idx] = w;
            end
            q.push_back(e);
         end
         m_seen = 1'b1;
      end
   end

   always @(negedge clk_i) begin : monitor
      logic exp_acc;
      if (!rst_i) begin
         n_tests++;
         if (mem_d_ack_o !== 1'b0 || mem_d_accept_o !== 1'b0 || mem_d_resp_tag_o !== 11'h0 ||
             mem_d_data_rd_o !== 32'h0 || mem_d_error_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs cyc=%0d got ack=%b acc=%b tag=%h data=%h err=%b want all 0",
                     cyc, mem_d_ack_o, mem_d_accept_o, mem_d_resp_tag_o, mem_d_data_rd_o, mem_d_error_o);
         end
         m_acc = 1'b0;
      end else begin
         exp_acc = m_seen && (q.size() < MAXO);
         n_tests++;
         if (mem_d_accept_o !== exp_acc) begin
            n_fail++;
            $display("FAIL accept cyc=%0d got %b want %b", cyc, mem_d_accept_o, exp_acc);
         end
         m_acc = exp_acc;
         n_tests++;
         if (q.size() > 0 && q[0].due == cyc) begin
            if (mem_d_ack_o !== 1'b1 || mem_d_resp_tag_o !== q[0].tag ||
                mem_d_data_rd_o !== q[0].data || mem_d_error_o !== q[0].err) begin
               n_fail++;
               $display("FAIL model_ack cyc=%0d got ack=%b tag=%h data=%h err=%b want ack=1 tag=%h data=%h err=%b",
                        cyc, mem_d_ack_o, mem_d_resp_tag_o, mem_d_data_rd_o, mem_d_error_o,
                        q[0].tag, q[0].data, q[0].err);
            end
            void'(q.pop_front());
         end else if (mem_d_ack_o !== 1'b0 || mem_d_resp_tag_o !== 11'h0 ||
                      mem_d_data_rd_o !== 32'h0 || mem_d_error_o !== 1'b0) begin
            n_fail++;
            $display("FAIL model_idle cyc=%0d got ack=%b tag=%h data=%h err=%b want all 0",
                     cyc, mem_d_ack_o, mem_d_resp_tag_o, mem_d_data_rd_o, mem_d_error_o);
         end
      end
   end

   // ---------------- drivers ----------------
   typedef struct {
      logic [2:0]  op;   // 0 rd, 1 wr, 2 flush, 3 invalidate, 4 writeback
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [10:0] tag;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   function automatic vec_t mkv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be, input logic [10:0] t,
                                input logic [31:0] xd, input logic xe);
      vec_t v;
      v.op = op; v.addr = a; v.wd = wd; v.be = be; v.tag = t; v.exp_data = xd; v.exp_err = xe;
      return v;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [10:0] t);
      mem_d_addr_i       = a;
      mem_d_data_wr_i    = wd;
      mem_d_req_tag_i    = t;
      mem_d_rd_i         = (op == 3'd0);
      mem_d_wr_i         = (op == 3'd1) ? be : 4'h0;
      mem_d_flush_i      = (op == 3'd2);
      mem_d_invalidate_i = (op == 3'd3);
      mem_d_writeback_i  = (op == 3'd4);
      mem_d_cacheable_i  = $urandom_range(0, 1) == 1;
   endtask

   task automatic idle();
      mem_d_addr_i = 32'h0; mem_d_data_wr_i = 32'h0; mem_d_req_tag_i = 11'h0;
      mem_d_rd_i = 1'b0; mem_d_wr_i = 4'h0; mem_d_flush_i = 1'b0;
      mem_d_invalidate_i = 1'b0; mem_d_writeback_i = 1'b0; mem_d_cacheable_i = 1'b0;
   endtask

   // Called at posedge+2; returns at posedge+2 right after the firing edge
   task automatic issue(input vec_t v, input string name);
      logic got;
      got = 1'b0;
      drive(v.op, v.addr, v.wd, v.be, v.tag);
      for (int n = 0; n < 30 && !got; n++) begin
         @(negedge clk_i);
         got = mem_d_accept_o;
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s accept_timeout got accept=0 want 1 within 30 cycles", name);
      end
      @(posedge clk_i); #2;
      idle();
   endtask

   task automatic do_op(input vec_t v, input string name);
      logic        got, e;
      logic [10:0] t;
      logic [31:0] d;
      got = 1'b0; t = '0; d = '0; e = 1'b0;
      issue(v, name);
      for (int n = 0; n < 12 && !got; n++) begin
         @(negedge clk_i);
         if (mem_d_ack_o) begin
            got = 1'b1; t = mem_d_resp_tag_o; d = mem_d_data_rd_o; e = mem_d_error_o;
         end
      end
      n_tests++;
      if (!got || t !== v.tag || d !== v.exp_data || e !== v.exp_err) begin
         n_fail++;
         $display("FAIL %s got ack=%b tag=%h data=%h err=%b want tag=%h data=%h err=%b",
                  name, got, t, d, e, v.tag, v.exp_data, v.exp_err);
      end
      @(posedge clk_i); #2;
   endtask

   task automatic check_acc(input logic want, input string name);
      @(negedge clk_i);
      n_tests++;
      if (mem_d_accept_o !== want || mem_d_ack_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s got accept=%b ack=%b want accept=%b ack=0", name, mem_d_accept_o, mem_d_ack_o, want);
      end
      @(posedge clk_i); #2;
   endtask

   // ---------------- stimulus ----------------
   vec_t tbl[16];
   logic pat[8];
   logic exp_pat[8];

   initial begin
      logic [10:0] t;
      logic        acc_now, holding, fired;
      int          r;
      logic [31:0] a;

      tbl[0]  = mkv(3'd1, 32'h80001000, 32'h11223344, 4'hF, 11'h001, 32'h0, 1'b0);
      tbl[1]  = mkv(3'd1, 32'h80000010, 32'hDEADBEEF, 4'hF, 11'h005, 32'h0, 1'b0);
      tbl[2]  = mkv(3'd0, 32'h80000010, 32'h0,        4'h0, 11'h006, 32'hDEADBEEF, 1'b0);
      tbl[3]  = mkv(3'd1, 32'h80000010, 32'h0000AB00, 4'h2, 11'h007, 32'h0, 1'b0);
      tbl[4]  = mkv(3'd0, 32'h80000010, 32'h0,        4'h0, 11'h008, 32'hDEADABEF, 1'b0);
      tbl[5]  = mkv(3'd0, 32'h00001000, 32'h0,        4'h0, 11'h7FF, 32'h0, 1'b1);
      tbl[6]  = mkv(3'd1, 32'h00001000, 32'hFFFFFFFF, 4'hF, 11'h009, 32'h0, 1'b1);
      tbl[7]  = mkv(3'd0, 32'h80001000, 32'h0,        4'h0, 11'h00A, 32'h11223344, 1'b0);
      tbl[8]  = mkv(3'd2, 32'h80000010, 32'h0,        4'h0, 11'h003, 32'h0, 1'b0);
      tbl[9]  = mkv(3'd3, 32'h80000010, 32'h0,        4'h0, 11'h004, 32'h0, 1'b0);
      tbl[10] = mkv(3'd4, 32'h00000040, 32'h0,        4'h0, 11'h00C, 32'h0, 1'b0);
      tbl[11] = mkv(3'd1, 32'h80000013, 32'h55000000, 4'h8, 11'h00E, 32'h0, 1'b0);
      tbl[12] = mkv(3'd0, 32'h80000012, 32'h0,        4'h0, 11'h00F, 32'h55ADABEF, 1'b0);
      tbl[13] = mkv(3'd1, 32'h8000FFFC, 32'hCAFEF00D, 4'hF, 11'h010, 32'h0, 1'b0);
      tbl[14] = mkv(3'd0, 32'h8000FFFC, 32'h0,        4'h0, 11'h011, 32'hCAFEF00D, 1'b0);
      tbl[15] = mkv(3'd0, 32'h80010000, 32'h0,        4'h0, 11'h012, 32'h0, 1'b1);
      exp_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      idle();
      repeat (3) @(posedge clk_i);
      #2;
      check_acc(1'b0, "reset_state");
      rst_i = 1'b1;
      check_acc(1'b0, "release_cycle0");
      check_acc(1'b1, "release_cycle1");

      for (int i = 0; i < 16; i++) do_op(tbl[i], $sformatf("vec%0d", i));

      // Read held every cycle: accept throttles at MAX_OUTSTANDING
      t = 11'h100;
      drive(3'd0, 32'h80000010, 32'h0, 4'h0, t);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         acc_now = mem_d_accept_o;
         pat[i]  = acc_now;
         @(posedge clk_i); #2;
         if (acc_now) begin
            t = t + 11'h1;
            drive(3'd0, 32'h80000010, 32'h0, 4'h0, t);
         end
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (pat[i] !== exp_pat[i]) begin
            n_fail++;
            $display("FAIL held_rd_accept[%0d] got %b want %b", i, pat[i], exp_pat[i]);
         end
      end
      repeat (6) @(posedge clk_i);
      #2;

      // Reset with two reads in flight
      drive(3'd0, 32'h80000010, 32'h0, 4'h0, 11'h020);
      @(posedge clk_i); #2;
      drive(3'd0, 32'h80001000, 32'h0, 4'h0, 11'h021);
      @(posedge clk_i); #2;
      idle();
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) check_acc(1'b0, "rst_inflight");
      rst_i = 1'b1;
      check_acc(1'b0, "rst2_release_cycle0");
      check_acc(1'b1, "rst2_release_cycle1");
      do_op(mkv(3'd0, 32'h80000010, 32'h0, 4'h0, 11'h022, 32'h55ADABEF, 1'b0), "post_rst_rd0");
      do_op(mkv(3'd0, 32'h80001000, 32'h0, 4'h0, 11'h023, 32'h11223344, 1'b0), "post_rst_rd1");

      // Randomized traffic over a preloaded set of 16 words plus out-of-window addresses
      for (int i = 0; i < 16; i++)
         issue(mkv(3'd1, 32'h80000100 + 32'(i * 4), $urandom, 4'hF, 11'(i), 32'h0, 1'b0), "preload");
      holding = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!holding && $urandom_range(0, 3) != 0) begin
            r = $urandom_range(0, 7);
            a = 32'h80000100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            if (r == 7) a = {($urandom_range(0, 1) == 1) ? 16'h8001 : 16'h7FFF, 16'($urandom)};
            if (r <= 2 || (r == 7 && $urandom_range(0, 1) == 1))
               drive(3'd0, a, 32'h0, 4'h0, 11'($urandom));
            else if (r <= 5 || r == 7)
               drive(3'd1, a, $urandom, 4'($urandom_range(1, 15)), 11'($urandom));
            else
               drive(3'($urandom_range(2, 4)), a, 32'h0, 4'h0, 11'($urandom));
            holding = 1'b1;
         end
         @(negedge clk_i);
         fired = holding && mem_d_accept_o;
         @(posedge clk_i); #2;
         if (fired) begin
            holding = 1'b0;
            idle();
         end
      end
      idle();
      repeat (10) @(posedge clk_i);
      #2;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
